// File: rtl/bcd_updown_counter_pkg.sv
// Shared constants and BCD conversion helpers for the BCD up/down counter.
// Pure functions only; no state.
// Used for elaboration-time constants and the combinational load check.
package bcd_cnt_pkg;

  localparam int DIGIT_W    = 4;
  localparam int MAX_DIGITS = 6;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;
  localparam logic [DIGIT_W-1:0] DIGIT_MIN = 4'd0;

  // Decimal value of the low 'digits' BCD digits; illegal nibbles are not screened here.
  function automatic logic [31:0] bcd_to_bin(input logic [DIGIT_W*MAX_DIGITS-1:0] bcd,
                                             input int digits);
    logic [31:0] v;
    v = '0;
    for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
      if (i < digits) v = v * 32'd10 + 32'(bcd[DIGIT_W*i +: DIGIT_W]);
    end
    return v;
  endfunction

  // True when every one of the low 'digits' nibbles is 0..9.
  function automatic logic bcd_is_legal(input logic [DIGIT_W*MAX_DIGITS-1:0] bcd,
                                        input int digits);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < digits && bcd[DIGIT_W*i +: DIGIT_W] > DIGIT_MAX) ok = 1'b0;
    end
    return ok;
  endfunction

  // Integer to packed BCD, digit 0 in the low nibble.
  function automatic logic [DIGIT_W*MAX_DIGITS-1:0] int_to_bcd(input logic [31:0] value);
    logic [DIGIT_W*MAX_DIGITS-1:0] r;
    logic [31:0] v;
    v = value;
    r = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      r[DIGIT_W*i +: DIGIT_W] = DIGIT_W'(v % 32'd10);
      v = v / 32'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_updown_counter_if.sv
// Control and status bundle of one BCD counter field.
// master drives tick/adjust/load requests, slave returns count and pulses.
// No handshake: every request is sampled on each rising clock edge.
interface bcd_updown_counter_if #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 11
);
  logic                  en;
  logic                  incr;
  logic                  dcr;
  logic                  load;
  logic [4*DIGITS-1:0]   load_bcd;
  logic [4*DIGITS-1:0]   count_bcd;
  logic [BIN_W-1:0]      count_bin;
  logic                  carry_out;
  logic                  borrow_out;
  logic                  at_max;
  logic                  at_min;
  logic                  load_err;

  modport master (
    output en, incr, dcr, load, load_bcd,
    input  count_bcd, count_bin, carry_out, borrow_out, at_max, at_min, load_err
  );

  modport slave (
    input  en, incr, dcr, load, load_bcd,
    output count_bcd, count_bin, carry_out, borrow_out, at_max, at_min, load_err
  );
endinterface

// File: rtl/bcd_updown_counter_digit.sv
// One combinational BCD digit cell of the ripple chain.
// Zero latency; purely combinational.
// Steps only when cin is set; cout requests a step of the next digit.
module bcd_digit
  import bcd_cnt_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  input  logic               up,
  input  logic               cin,
  output logic [DIGIT_W-1:0] step,
  output logic               cout
);

  // Increment with 9->0 carry or decrement with 0->9 borrow when enabled.
  always_comb begin
    step = digit;
    cout = 1'b0;
    if (cin) begin
      if (up) begin
        if (digit >= DIGIT_MAX) begin
          step = DIGIT_MIN;
          cout = 1'b1;
        end else begin
          step = digit + 4'd1;
        end
      end else begin
        if (digit == DIGIT_MIN) begin
          step = DIGIT_MAX;
          cout = 1'b1;
        end else begin
          step = digit - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with binary mirror, load check and wrap/saturate limits.
// Accepted operations appear one cycle after the sampling edge; at_max/at_min are combinational.
// No backpressure: every request is acted on or rejected in the cycle it is sampled.
module bcd_updown_counter
  import bcd_cnt_pkg::*;
#(
  parameter int DIGITS  = 3,
  parameter int BIN_W   = 11,
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = 999,
  parameter int WRAP    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  bcd_updown_counter_if.slave    bus
);

  localparam int CW = DIGIT_W * DIGITS;
  localparam int WW = DIGIT_W * MAX_DIGITS;
  localparam logic [CW-1:0]    MIN_BCD = CW'(int_to_bcd(32'(MIN_VAL)));
  localparam logic [CW-1:0]    MAX_BCD = CW'(int_to_bcd(32'(MAX_VAL)));
  localparam logic [BIN_W-1:0] MIN_BIN = BIN_W'(MIN_VAL);
  localparam logic [BIN_W-1:0] MAX_BIN = BIN_W'(MAX_VAL);

  logic [CW-1:0]    count_q;
  logic [BIN_W-1:0] bin_q;
  logic             carry_q;
  logic             borrow_q;
  logic             lerr_q;

  // en and incr merge into one +1; opposing requests cancel.
  logic up_req, dn_req, do_up, do_dn;
  assign up_req = bus.en | bus.incr;
  assign dn_req = bus.dcr;
  assign do_up  = up_req & ~dn_req;
  assign do_dn  = dn_req & ~up_req;

  // Ripple chain computes count +/- 1 in BCD.
  logic [CW-1:0]   step_bcd;
  logic [DIGITS:0] ripple;
  assign ripple[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .digit (count_q[DIGIT_W*g +: DIGIT_W]),
      .up    (do_up),
      .cin   (ripple[g]),
      .step  (step_bcd[DIGIT_W*g +: DIGIT_W]),
      .cout  (ripple[g+1])
    );
  end

  // Limit detection; a ripple out of the top digit also counts as hitting the limit.
  logic at_max, at_min, hit_top, hit_bot;
  assign at_max  = (count_q == MAX_BCD);
  assign at_min  = (count_q == MIN_BCD);
  assign hit_top = at_max | ripple[DIGITS];
  assign hit_bot = at_min | ripple[DIGITS];

  // Load is accepted only for legal digits inside [MIN_VAL, MAX_VAL].
  logic [WW-1:0] load_wide;
  logic [31:0]   load_val;
  logic          load_ok;
  assign load_wide = WW'(bus.load_bcd);
  assign load_val  = bcd_to_bin(load_wide, DIGITS);
  assign load_ok   = bcd_is_legal(load_wide, DIGITS) &&
                     (load_val >= 32'(MIN_VAL)) && (load_val <= 32'(MAX_VAL));

  // Count, mirror and pulse registers; priority is rst > load > net step.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= MIN_BCD;
      bin_q    <= MIN_BIN;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      lerr_q   <= 1'b0;
    end else begin
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      lerr_q   <= 1'b0;
      if (bus.load) begin
        if (load_ok) begin
          count_q <= bus.load_bcd;
          bin_q   <= BIN_W'(load_val);
        end else begin
          lerr_q  <= 1'b1;
        end
      end else if (do_up) begin
        if (!hit_top) begin
          count_q <= step_bcd;
          bin_q   <= bin_q + 1'b1;
        end else if (WRAP != 0) begin
          count_q <= MIN_BCD;
          bin_q   <= MIN_BIN;
          carry_q <= 1'b1;
        end
      end else if (do_dn) begin
        if (!hit_bot) begin
          count_q  <= step_bcd;
          bin_q    <= bin_q - 1'b1;
        end else if (WRAP != 0) begin
          count_q  <= MAX_BCD;
          bin_q    <= MAX_BIN;
          borrow_q <= 1'b1;
        end
      end
    end
  end

  assign bus.count_bcd  = count_q;
  assign bus.count_bin  = bin_q;
  assign bus.carry_out  = carry_q;
  assign bus.borrow_out = borrow_q;
  assign bus.at_max     = at_max;
  assign bus.at_min     = at_min;
  assign bus.load_err   = lerr_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench for bcd_updown_counter: three configurations (wrap 0..999, saturate 0..999,
// wrap 100..250) driven in lockstep and compared against a decimal reference model,
// plus directed spot checks with hand-derived constants.
module tb_bcd_updown_counter;

  logic clk;
  logic rst;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_updown_counter_if #(.DIGITS(3), .BIN_W(11)) ia ();
  bcd_updown_counter_if #(.DIGITS(3), .BIN_W(11)) ib ();
  bcd_updown_counter_if #(.DIGITS(3), .BIN_W(11)) ic ();

  bcd_updown_counter #(.DIGITS(3), .BIN_W(11), .MIN_VAL(0), .MAX_VAL(999), .WRAP(1))
    dut_a (.clk(clk), .rst(rst), .bus(ia));
  bcd_updown_counter #(.DIGITS(3), .BIN_W(11), .MIN_VAL(0), .MAX_VAL(999), .WRAP(0))
    dut_b (.clk(clk), .rst(rst), .bus(ib));
  bcd_updown_counter #(.DIGITS(3), .BIN_W(11), .MIN_VAL(100), .MAX_VAL(250), .WRAP(1))
    dut_c (.clk(clk), .rst(rst), .bus(ic));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain decimal count per configuration.
  int min_v[3]  = '{0, 0, 100};
  int max_v[3]  = '{999, 999, 250};
  bit wrap_v[3] = '{1'b1, 1'b0, 1'b1};
  int m_cnt[3];
  bit m_co[3], m_bo[3], m_le[3];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] to_bcd(input int v);
    return 32'(((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10));
  endfunction

  task automatic model_step(input int k, input bit r, input bit e, input bit i,
                            input bit d, input bit l, input logic [11:0] lb);
    int d0, d1, d2, v;
    bit up, dn;
    m_co[k] = 0; m_bo[k] = 0; m_le[k] = 0;
    if (r) begin
      m_cnt[k] = min_v[k];
    end else if (l) begin
      d0 = int'(lb[3:0]); d1 = int'(lb[7:4]); d2 = int'(lb[11:8]);
      v  = d2 * 100 + d1 * 10 + d0;
      if (d0 <= 9 && d1 <= 9 && d2 <= 9 && v >= min_v[k] && v <= max_v[k]) m_cnt[k] = v;
      else m_le[k] = 1;
    end else begin
      up = e | i;
      dn = d;
      if (up && !dn) begin
        if (m_cnt[k] < max_v[k]) m_cnt[k]++;
        else if (wrap_v[k]) begin m_cnt[k] = min_v[k]; m_co[k] = 1; end
      end else if (dn && !up) begin
        if (m_cnt[k] > min_v[k]) m_cnt[k]--;
        else if (wrap_v[k]) begin m_cnt[k] = max_v[k]; m_bo[k] = 1; end
      end
    end
  endtask

  task automatic check_dut(input string n, input int k, input logic [11:0] cb,
                           input logic [10:0] cbin, input logic co, input logic bo,
                           input logic amax, input logic amin, input logic le);
    chk({n, ".count_bcd"}, 32'(cb), to_bcd(m_cnt[k]));
    chk({n, ".count_bin"}, 32'(cbin), 32'(m_cnt[k]));
    chk({n, ".carry_out"}, 32'(co), 32'(m_co[k]));
    chk({n, ".borrow_out"}, 32'(bo), 32'(m_bo[k]));
    chk({n, ".at_max"}, 32'(amax), 32'(m_cnt[k] == max_v[k]));
    chk({n, ".at_min"}, 32'(amin), 32'(m_cnt[k] == min_v[k]));
    chk({n, ".load_err"}, 32'(le), 32'(m_le[k]));
  endtask

  // One clock: drive at negedge, update model at posedge, sample 1 ns later.
  task automatic apply(input bit r, input bit e, input bit i, input bit d,
                       input bit l, input logic [11:0] lb);
    @(negedge clk);
    rst = r;
    ia.en = e; ia.incr = i; ia.dcr = d; ia.load = l; ia.load_bcd = lb;
    ib.en = e; ib.incr = i; ib.dcr = d; ib.load = l; ib.load_bcd = lb;
    ic.en = e; ic.incr = i; ic.dcr = d; ic.load = l; ic.load_bcd = lb;
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k, r, e, i, d, l, lb);
    #1;
    check_dut("a", 0, ia.count_bcd, ia.count_bin, ia.carry_out, ia.borrow_out,
              ia.at_max, ia.at_min, ia.load_err);
    check_dut("b", 1, ib.count_bcd, ib.count_bin, ib.carry_out, ib.borrow_out,
              ib.at_max, ib.at_min, ib.load_err);
    check_dut("c", 2, ic.count_bcd, ic.count_bin, ic.carry_out, ic.borrow_out,
              ic.at_max, ic.at_min, ic.load_err);
  endtask

  initial begin
    logic [11:0] lb;
    int sel;
    int pick[4] = '{0, 100, 250, 999};
    rst = 1'b0;
    ia.en = 0; ia.incr = 0; ia.dcr = 0; ia.load = 0; ia.load_bcd = '0;
    ib.en = 0; ib.incr = 0; ib.dcr = 0; ib.load = 0; ib.load_bcd = '0;
    ic.en = 0; ic.incr = 0; ic.dcr = 0; ic.load = 0; ic.load_bcd = '0;

    // Reset state
    apply(1, 0, 0, 0, 0, 12'h000);
    chk("rst_a_bcd", 32'(ia.count_bcd), 32'h000);
    chk("rst_c_bcd", 32'(ic.count_bcd), 32'h100);
    chk("rst_c_bin", 32'(ic.count_bin), 32'd100);

    // Count up 12 ticks
    for (int n = 0; n < 12; n++) apply(0, 1, 0, 0, 0, 12'h000);
    chk("up12_bcd", 32'(ia.count_bcd), 32'h012);
    chk("up12_bin", 32'(ia.count_bin), 32'd12);

    // Wrap up from 999; saturate config holds
    apply(0, 0, 0, 0, 1, 12'h999);
    chk("ld999_c_err", 32'(ic.load_err), 32'd1);
    apply(0, 1, 0, 0, 0, 12'h000);
    chk("wrapup_bcd", 32'(ia.count_bcd), 32'h000);
    chk("wrapup_carry", 32'(ia.carry_out), 32'd1);
    chk("wrapup_atmin", 32'(ia.at_min), 32'd1);
    chk("sat_top_bcd", 32'(ib.count_bcd), 32'h999);
    chk("sat_top_carry", 32'(ib.carry_out), 32'd0);
    apply(0, 0, 0, 0, 0, 12'h000);
    chk("carry_1cyc", 32'(ia.carry_out), 32'd0);

    // Wrap down from 0
    apply(0, 0, 0, 1, 0, 12'h000);
    chk("wrapdn_bcd", 32'(ia.count_bcd), 32'h999);
    chk("wrapdn_bin", 32'(ia.count_bin), 32'd999);
    chk("wrapdn_borrow", 32'(ia.borrow_out), 32'd1);
    apply(0, 0, 0, 0, 0, 12'h000);
    chk("borrow_1cyc", 32'(ia.borrow_out), 32'd0);
    apply(0, 0, 0, 0, 1, 12'h000);
    apply(0, 0, 0, 1, 0, 12'h000);
    chk("sat_bot_bcd", 32'(ib.count_bcd), 32'h000);
    chk("sat_bot_borrow", 32'(ib.borrow_out), 32'd0);

    // Simultaneous inputs
    apply(0, 0, 0, 0, 1, 12'h499);
    apply(0, 1, 1, 0, 0, 12'h000);
    chk("en_incr_bcd", 32'(ia.count_bcd), 32'h500);
    chk("en_incr_bin", 32'(ia.count_bin), 32'd500);
    apply(0, 1, 0, 1, 0, 12'h000);
    chk("en_dcr_bcd", 32'(ia.count_bcd), 32'h500);

    // Load validation and range limits
    apply(0, 0, 0, 0, 1, 12'h3A1);
    chk("ld_bad_bcd", 32'(ia.count_bcd), 32'h500);
    chk("ld_bad_err", 32'(ia.load_err), 32'd1);
    apply(0, 0, 0, 0, 1, 12'h250);
    chk("ld250_bcd", 32'(ia.count_bcd), 32'h250);
    chk("ld250_bin", 32'(ia.count_bin), 32'd250);
    chk("ld250_c_max", 32'(ic.at_max), 32'd1);
    apply(0, 1, 0, 0, 0, 12'h000);
    chk("c_wrap_bcd", 32'(ic.count_bcd), 32'h100);
    chk("c_wrap_carry", 32'(ic.carry_out), 32'd1);
    apply(0, 0, 0, 0, 1, 12'h050);
    chk("c_ld050_err", 32'(ic.load_err), 32'd1);
    chk("c_ld050_bcd", 32'(ic.count_bcd), 32'h100);

    // Reset overrides load and en
    apply(0, 0, 0, 0, 1, 12'h777);
    apply(1, 1, 0, 0, 1, 12'h123);
    chk("rstmid_bcd", 32'(ia.count_bcd), 32'h000);
    chk("rstmid_carry", 32'(ia.carry_out), 32'd0);
    chk("rstmid_err", 32'(ia.load_err), 32'd0);
    chk("rstmid_c_bcd", 32'(ic.count_bcd), 32'h100);

    // Randomised traffic against the model
    for (int n = 0; n < 3000; n++) begin
      sel = int'($urandom_range(0, 19));
      if (sel == 0)      lb = 12'(to_bcd(int'($urandom_range(0, 999))));
      else if (sel == 1) lb = 12'(to_bcd(pick[$urandom_range(0, 3)]));
      else               lb = 12'($urandom);
      apply(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 0),
            (sel < 3), lb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_updown_counter.md
Name: bcd_updown_counter

Overview:
Parametrised multi-digit BCD up/down counter with a lock-stepped binary mirror. It is the generalised calendar/clock field counter for year, day and minute fields. It takes a carry-in tick from the lower field (en) and user adjust pulses (incr/dcr), and supports load, configurable range, and wrap or saturate mode. It emits carry/borrow pulses so that fields can be chained.

Parameters:
DIGITS, 3, number of BCD digits (1..6)
BIN_W, 11, width of the binary mirror; must satisfy 2**BIN_W > MAX_VAL
MIN_VAL, 0, lowest legal count (decimal)
MAX_VAL, 999, highest legal count (decimal); MIN_VAL < MAX_VAL < 10**DIGITS
WRAP, 1, 1 = wrap at limits, 0 = saturate at limits

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
en  in  1  carry-in tick from lower field, count +1
incr  in  1  user increment pulse, count +1
dcr  in  1  user decrement pulse, count -1
load  in  1  load load_bcd into the count
load_bcd  in  4*DIGITS  value to load; digit 0 in bits [3:0]
count_bcd  out  4*DIGITS  current count as BCD; digit 0 is least significant
count_bin  out  BIN_W  current count in binary, always equal to the decimal value of count_bcd
carry_out  out  1  one-cycle pulse when an up-step wraps MAX_VAL->MIN_VAL
borrow_out  out  1  one-cycle pulse when a down-step wraps MIN_VAL->MAX_VAL
at_max  out  1  combinational, count == MAX_VAL
at_min  out  1  combinational, count == MIN_VAL
load_err  out  1  one-cycle pulse when a load is rejected

Behaviour:
- All state is registered on the rising edge of clk; an accepted operation is visible on count_bcd/count_bin on the cycle after the sampling edge.
- Reset (synchronous, active-high):
  - count_bcd = BCD(MIN_VAL), count_bin = MIN_VAL.
  - carry_out = borrow_out = load_err = 0.
  - rst overrides every other input in the same cycle.
- Priority each cycle: rst > load > net step.
- Net step:
  - up = en | incr, so en and incr together give +1, not +2.
  - down = dcr.
  - up & down together give no change and no pulses.
- Up-step:
  - Below MAX_VAL: +1, with BCD ripple (a digit at 9 goes to 0 and carries into the next digit).
  - At MAX_VAL with WRAP=1: go to MIN_VAL and assert carry_out for one cycle.
  - At MAX_VAL with WRAP=0: hold, no pulse.
- Down-step:
  - Above MIN_VAL: -1, with BCD borrow (a digit at 0 goes to 9 and borrows from the next digit).
  - At MIN_VAL with WRAP=1: go to MAX_VAL and assert borrow_out.
  - At MIN_VAL with WRAP=0: hold, no pulse.
- Load:
  - Accepted only if every digit is 0..9 and MIN_VAL <= value <= MAX_VAL.
  - When accepted, count_bin is loaded with the binary equivalent in the same cycle.
  - Otherwise the count is unchanged and load_err pulses for one cycle.
  - A load cycle ignores en/incr/dcr.
- The binary mirror steps by exactly ±1, or jumps to MIN_VAL/MAX_VAL/load value, in the same cycle as the BCD count. It never diverges from the BCD count.
- Pulses (carry_out, borrow_out, load_err) are registered, high for exactly one cycle, and deassert the next cycle unless the condition recurs.
- No illegal BCD digit ever appears on count_bcd.

Decomposition:
- Package bcd_cnt_pkg holds:
  - BCD digit width constant (4).
  - Digit max/min constants (9/0).
  - Function to convert BCD to binary (used for load and range compare).
  - Function to convert integer to BCD (used for the MIN_VAL/MAX_VAL constants).
- Sub-module bcd_digit is one combinational digit cell:
  - Inputs: digit value, up/down request, carry/borrow in.
  - Outputs: next digit value, carry/borrow out.
  - Instantiated DIGITS times in a generate chain.
- The top level owns the registers, limit detection, wrap/saturate mux, load check and mirror.

Test Plan:
- Reset and count up: assert rst, then 12 cycles of en=1 -> count_bcd=0x012, count_bin=12, carry_out never high.
- Wrap up: load 999, then en=1 for one cycle -> count_bcd=0x000, count_bin=0, carry_out=1 for exactly one cycle, at_min=1.
- Wrap down: count 0, dcr=1 -> count_bcd=0x999, count_bin=999, borrow_out=1 for exactly one cycle. Then rebuild with WRAP=0 and apply dcr at 0 -> count stays 0 and no pulse.
- Simultaneous inputs: count 0x499 with en=1, incr=1 -> 0x500 (single step). Then en=1, dcr=1 -> stays 0x500.
- Load validation: load_bcd=0x3A1 -> unchanged, load_err=1. load_bcd=0x250 -> count 0x250, count_bin=250. With MIN_VAL=100, load 0x050 -> rejected.
- Reset mid-operation: rst=1 together with load=1 and en=1 at count 0x777 -> next cycle count = MIN_VAL and all pulses 0.
